// File: rtl/vga_timing_pattern.sv
// 640x480@60 VGA timing and 8-colour bar generator on a CLOCK_50/2 pixel clock.
// Optional white grid overlay when VGA_PATTERN_GRID_EN is defined.
module vga_timing_pattern #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_CLK,
    output logic       VGA_SYNC_N,
    output logic       VGA_BLANK_N,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic [2:0] ohs,
    output logic [2:0] ovs
);

    typedef enum logic [2:0] {
        PH_VISIBLE = 3'd0,
        PH_FRONT   = 3'd1,
        PH_SYNC    = 3'd2,
        PH_BACK    = 3'd3
    } phase_t;

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    function automatic phase_t phase_of(
        input logic [9:0] c,
        input int         vis,
        input int         fp,
        input int         sy
    );
        int n;
        n = int'(c);
        if (n < vis) begin
            return PH_VISIBLE;
        end else if (n < vis + fp) begin
            return PH_FRONT;
        end else if (n < vis + fp + sy) begin
            return PH_SYNC;
        end else begin
            return PH_BACK;
        end
    endfunction

    logic       vga_clk_q, vga_clk_d;
    logic [9:0] hcnt_q, hcnt_d;
    logic [9:0] vcnt_q, vcnt_d;
    phase_t     ohs_q, ohs_d;
    phase_t     ovs_q, ovs_d;
    logic       pe;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            vga_clk_q <= 1'b0;
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            ohs_q     <= PH_VISIBLE;
            ovs_q     <= PH_VISIBLE;
        end else begin
            vga_clk_q <= vga_clk_d;
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            ohs_q     <= ohs_d;
            ovs_q     <= ovs_d;
        end
    end

    // Advance on the edge where VGA_CLK falls so data is settled at its rise.
    always_comb begin
        vga_clk_d = ~vga_clk_q;
        pe        = vga_clk_q;
        hcnt_d    = hcnt_q;
        vcnt_d    = vcnt_q;
        if (pe) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
            end else begin
                hcnt_d = hcnt_q + 10'd1;
            end
        end
        ohs_d = phase_of(hcnt_d, H_VISIBLE, H_FRONT, H_SYNC);
        ovs_d = phase_of(vcnt_d, V_VISIBLE, V_FRONT, V_SYNC);
    end

    logic       active;
    logic [2:0] bar;
    logic [2:0] bar_rgb;
    logic [2:0] pix_rgb;

    assign active = RESET_N && (ohs_q == PH_VISIBLE) && (ovs_q == PH_VISIBLE);
    assign bar    = 3'(hcnt_q / 10'd80);

    always_comb begin
        bar_rgb = 3'b000;
        unique case (bar)
            3'd0: bar_rgb = 3'b111;
            3'd1: bar_rgb = 3'b110;
            3'd2: bar_rgb = 3'b011;
            3'd3: bar_rgb = 3'b010;
            3'd4: bar_rgb = 3'b101;
            3'd5: bar_rgb = 3'b100;
            3'd6: bar_rgb = 3'b001;
            3'd7: bar_rgb = 3'b000;
        endcase
    end

`ifdef VGA_PATTERN_GRID_EN
    logic grid;
    assign grid    = (hcnt_q[5:0] == 6'd0) || (vcnt_q[5:0] == 6'd0);
    assign pix_rgb = grid ? 3'b111 : bar_rgb;
`else
    assign pix_rgb = bar_rgb;
`endif

    assign VGA_R       = {8{active & pix_rgb[2]}};
    assign VGA_G       = {8{active & pix_rgb[1]}};
    assign VGA_B       = {8{active & pix_rgb[0]}};
    assign VGA_CLK     = vga_clk_q;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_BLANK_N = active;
    assign VGA_HS      = (ohs_q != PH_SYNC);
    assign VGA_VS      = (ovs_q != PH_SYNC);
    assign ohs         = ohs_q;
    assign ovs         = ovs_q;

endmodule

// File: tb/tb_vga_timing_pattern.sv
// Directed bench for vga_timing_pattern; vertical timing is shortened
// (16/3/2/4 lines) so a full frame fits in a short run.
module tb_vga_timing_pattern;

    logic       CLOCK_50;
    logic       RESET_N;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic       VGA_CLK, VGA_SYNC_N, VGA_BLANK_N, VGA_HS, VGA_VS;
    logic [2:0] ohs, ovs;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    bit mon_en  = 0;
    int hs_fall = 0;
    int vs_fall = 0;
    int hs_low  = 0;
    int vs_low  = 0;
    logic hs_prev = 1'b1;
    logic vs_prev = 1'b1;

    vga_timing_pattern #(
        .V_VISIBLE(16),
        .V_FRONT  (3),
        .V_SYNC   (2),
        .V_BACK   (4)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .RESET_N    (RESET_N),
        .VGA_R      (VGA_R),
        .VGA_G      (VGA_G),
        .VGA_B      (VGA_B),
        .VGA_CLK    (VGA_CLK),
        .VGA_SYNC_N (VGA_SYNC_N),
        .VGA_BLANK_N(VGA_BLANK_N),
        .VGA_HS     (VGA_HS),
        .VGA_VS     (VGA_VS),
        .ohs        (ohs),
        .ovs        (ovs)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    always @(negedge CLOCK_50) begin
        if (mon_en) begin
            if (hs_prev && !VGA_HS) hs_fall++;
            if (vs_prev && !VGA_VS) vs_fall++;
            if (!VGA_HS) hs_low++;
            if (!VGA_VS) vs_low++;
        end
        hs_prev = VGA_HS;
        vs_prev = VGA_VS;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_px(input string tag, input logic [23:0] rgb,
                          input logic blank, input logic hs,
                          input logic vs, input logic [2:0] oh,
                          input logic [2:0] ov);
        chk($sformatf("%s rgb", tag), {VGA_R, VGA_G, VGA_B}, rgb);
        chk($sformatf("%s blank_n", tag), VGA_BLANK_N, blank);
        chk($sformatf("%s hs", tag), VGA_HS, hs);
        chk($sformatf("%s vs", tag), VGA_VS, vs);
        chk($sformatf("%s ohs", tag), ohs, oh);
        chk($sformatf("%s ovs", tag), ovs, ov);
        chk($sformatf("%s sync_n", tag), VGA_SYNC_N, 1'b0);
    endtask

    // Pixel p is loaded by posedge 2p after reset release; sample 1 ns later.
    task automatic goto(input int v, input int h);
        int p;
        p = v * 800 + h;
        repeat (2 * p - cyc) @(posedge CLOCK_50);
        cyc = 2 * p;
        #1;
        chk($sformatf("clk@%0d,%0d", v, h), VGA_CLK, 1'b0);
    endtask

    task automatic chk_reset(input string tag);
        chk_px(tag, 24'h000000, 1'b0, 1'b1, 1'b1, 3'd0, 3'd0);
        chk($sformatf("%s vga_clk", tag), VGA_CLK, 1'b0);
    endtask

    initial begin
        RESET_N = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        chk_reset("por");
        RESET_N = 1'b1;
        cyc = 0;

        goto(2, 300);
        chk_px("pre_rst", 24'h00FF00, 1'b1, 1'b1, 1'b1, 3'd0, 3'd0);
        RESET_N = 1'b0;
        #1;
        chk_reset("mid_rst");
        repeat (3) @(negedge CLOCK_50);
        chk_reset("mid_rst_hold");
        RESET_N = 1'b1;
        cyc = 0;
        mon_en = 1'b1;

        goto(0, 0);
        chk_px("p0_0", 24'hFFFFFF, 1'b1, 1'b1, 1'b1, 3'd0, 3'd0);
        @(posedge CLOCK_50);
        #1;
        cyc++;
        chk("clk_odd", VGA_CLK, 1'b1);
        chk("hold_rgb", {VGA_R, VGA_G, VGA_B}, 24'hFFFFFF);

        goto(1, 0);
        chk_px("l1_x0", 24'hFFFFFF, 1'b1, 1'b1, 1'b1, 3'd0, 3'd0);
        goto(1, 80);
        chk_px("l1_x80", 24'hFFFF00, 1'b1, 1'b1, 1'b1, 3'd0, 3'd0);
        goto(1, 128);
`ifdef VGA_PATTERN_GRID_EN
        chk_px("l1_x128", 24'hFFFFFF, 1'b1, 1'b1, 1'b1, 3'd0, 3'd0);
`else
        chk_px("l1_x128", 24'hFFFF00, 1'b1, 1'b1, 1'b1, 3'd0, 3'd0);
`endif
        goto(1, 400);
        chk_px("l1_x400", 24'hFF0000, 1'b1, 1'b1, 1'b1, 3'd0, 3'd0);
        goto(1, 639);
        chk_px("l1_x639", 24'h000000, 1'b1, 1'b1, 1'b1, 3'd0, 3'd0);
        goto(1, 640);
        chk_px("l1_x640", 24'h000000, 1'b0, 1'b1, 1'b1, 3'd1, 3'd0);
        goto(1, 655);
        chk_px("l1_x655", 24'h000000, 1'b0, 1'b1, 1'b1, 3'd1, 3'd0);
        goto(1, 656);
        chk_px("l1_x656", 24'h000000, 1'b0, 1'b0, 1'b1, 3'd2, 3'd0);
        goto(1, 751);
        chk_px("l1_x751", 24'h000000, 1'b0, 1'b0, 1'b1, 3'd2, 3'd0);
        goto(1, 752);
        chk_px("l1_x752", 24'h000000, 1'b0, 1'b1, 1'b1, 3'd3, 3'd0);
        goto(1, 799);
        chk_px("l1_x799", 24'h000000, 1'b0, 1'b1, 1'b1, 3'd3, 3'd0);

        goto(15, 639);
        chk_px("l15_x639", 24'h000000, 1'b1, 1'b1, 1'b1, 3'd0, 3'd0);
        goto(16, 0);
        chk_px("l16_x0", 24'h000000, 1'b0, 1'b1, 1'b1, 3'd0, 3'd1);
        goto(16, 400);
        chk_px("l16_x400", 24'h000000, 1'b0, 1'b1, 1'b1, 3'd0, 3'd1);
        goto(18, 799);
        chk_px("l18_x799", 24'h000000, 1'b0, 1'b1, 1'b1, 3'd3, 3'd1);
        goto(19, 0);
        chk_px("l19_x0", 24'h000000, 1'b0, 1'b1, 1'b0, 3'd0, 3'd2);
        goto(20, 799);
        chk_px("l20_x799", 24'h000000, 1'b0, 1'b1, 1'b0, 3'd3, 3'd2);
        goto(21, 0);
        chk_px("l21_x0", 24'h000000, 1'b0, 1'b1, 1'b1, 3'd0, 3'd3);
        goto(24, 799);
        chk_px("l24_x799", 24'h000000, 1'b0, 1'b1, 1'b1, 3'd3, 3'd3);
        goto(25, 0);
        chk_px("wrap_0_0", 24'hFFFFFF, 1'b1, 1'b1, 1'b1, 3'd0, 3'd0);

        mon_en = 1'b0;
        chk("hs_pulses", hs_fall, 25);
        chk("vs_pulses", vs_fall, 1);
        chk("hs_low_cyc", hs_low, 25 * 192);
        chk("vs_low_cyc", vs_low, 2 * 1600);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/vga_timing_pattern.md
Name: vga_timing_pattern

Overview:
Stand-alone VGA test-pattern generator for the board's ADV7123-style video DAC. It divides CLOCK_50 by two to produce a 25 MHz pixel clock and generates 640x480@60 horizontal and vertical timing. It drives an 8-colour vertical bar pattern with sync and blank strobes. It also exports the horizontal and vertical timing-phase codes (ohs/ovs) for debug and simulation.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)

Ports:
CLOCK_50  in  1  50 MHz system clock; all flops are on its rising edge
RESET_N  in  1  asynchronous active-low reset
VGA_R  out  8  red level
VGA_G  out  8  green level
VGA_B  out  8  blue level
VGA_CLK  out  1  25 MHz pixel clock (CLOCK_50/2)
VGA_SYNC_N  out  1  DAC sync-on-green, tied 0
VGA_BLANK_N  out  1  low outside the active area
VGA_HS  out  1  horizontal sync, active low
VGA_VS  out  1  vertical sync, active low
ohs  out  3  horizontal phase code
ovs  out  3  vertical phase code

Behaviour:
- Clock and reset: one clock domain (CLOCK_50); reset is asynchronous and active-low on RESET_N.
- Pixel clock: VGA_CLK register toggles on every CLOCK_50 edge; reset value 0.
- Pixel enable (pe) is asserted on the CLOCK_50 edge where VGA_CLK goes 1->0. Counters and phases advance only on pe, so data is stable at each VGA_CLK rising edge.
- Counters: hcnt 0..799 (line = 800 pixels) and vcnt 0..524 (frame = 525 lines).
  - On pe, hcnt increments; at 799 it wraps to 0 and vcnt increments.
  - vcnt wraps from 524 to 0 on the same pe.
- Frame period is 420000 pixels = 840000 CLOCK_50 cycles = 16.8 ms.
- Phase codes (ohs from hcnt, ovs from vcnt): 0 VISIBLE, 1 FRONT porch, 2 SYNC, 3 BACK porch. Codes 4-7 are never produced.
  - h boundaries: 0-639 VISIBLE, 640-655 FRONT, 656-751 SYNC, 752-799 BACK.
  - v boundaries: 0-479 VISIBLE, 480-489 FRONT, 490-491 SYNC, 492-524 BACK.
- Phase codes are registered state that changes together with the counters (same pe edge, zero added latency).
- VGA_HS = 0 iff ohs==2. VGA_VS = 0 iff ovs==2. VGA_BLANK_N = 1 iff ohs==0 and ovs==0.
- Pattern: bar = hcnt/80, giving bars 0..7 = white, yellow, cyan, green, magenta, red, blue, black. Each channel is 8'hFF or 8'h00.
- RGB is forced to 0 whenever VGA_BLANK_N=0.
- All video outputs are combinational decodes of registered counters/phases; the pixel at hcnt=N is presented during the VGA_CLK period that follows the pe that loaded N.
- Reset (asynchronous, any time, including mid-frame) forces these values:
  - hcnt=0, vcnt=0, VGA_CLK=0, ohs=0, ovs=0.
  - VGA_HS=1, VGA_VS=1.
  - VGA_BLANK_N=0 and RGB=0 while RESET_N is low.
- After RESET_N rises, output resumes at pixel (0,0) of a fresh frame.
- VGA_SYNC_N=0 at all times.

Optional Feature:
VGA_PATTERN_GRID_EN
- Defined: a white grid overlay (RGB FF/FF/FF) is drawn on active pixels where hcnt%64==0 or vcnt%64==0. Timing is unchanged.
- Undefined: plain colour bars only. Grid logic is not synthesized.

Test Plan:
- Release RESET_N, run 840000 CLOCK_50 cycles -> exactly one VS low pulse of 2 lines (1600 pixels); exactly 525 HS pulses; VGA_CLK measures 25 MHz.
- Line timing -> HS low for hcnt 656..751 (96 pixels, 192 CLOCK_50 cycles); ohs sequence 0,1,2,3 with lengths 640/16/96/48 pixels.
- Pixels at line 0: x=0 -> FF/FF/FF; x=80 -> FF/FF/00; x=400 -> FF/00/00; x=639 -> 00/00/00; x=640 -> BLANK_N=0, RGB=0.
- Vertical blanking: vcnt=480..524 -> BLANK_N=0 and RGB=0 for all hcnt; ovs=1 at 480, 2 at 490, 3 at 492, 0 at 0.
- Assert RESET_N low at line 200, pixel 300 -> outputs immediately take reset values; after release, next active pixel is (0,0) and first VS follows 840000-cycle-aligned timing.
- With VGA_PATTERN_GRID_EN: pixel (64,10) and (10,128) are FF/FF/FF; pixel (65,65) shows its bar colour.
